i2c_rd_framer: RTL and testbench

- Downstream consumer of the I2C read path.
- Captures each byte the I2C master reads back (`rcv_data` qualified by `recv_done`) and buffers it in a local FIFO.
- Wraps the buffered bytes into framed packets: header, length, payload, checksum.
- Streams the packets byte-by-byte over a valid/ready handshake to the UART transmitter in the clk50mhz domain.

---
 rtl/i2c_frame_pkg.sv | 16 +
 rtl/rx_byte_fifo.sv | 54 +++++
 rtl/i2c_rd_framer.sv | 160 ++++++++++++++++
 tb/tb_i2c_rd_framer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_frame_pkg.sv
// Shared framer definitions: FSM encoding, default header byte and checksum step.
package i2c_frame_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HDR     = 3'd1;
  localparam logic [2:0] ST_LEN     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_CSUM    = 3'd4;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  function automatic logic [7:0] csum_upd(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/rx_byte_fifo.sv
// Synchronous byte FIFO, first-word-fall-through; push visible in count next cycle.
// Push while full is refused unless a pop happens in the same cycle.
module rx_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [7:0]               wdata_i,
  input  logic                     pop_i,
  output logic [7:0]               rdata_o,
  output logic [7:0]               rnext_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  // Lookahead so the consumer can register the byte that follows a pop.
  assign rnext_o = mem_q[rd_ptr_q + AW'(1)];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/i2c_rd_framer.sv
// Buffers I2C read bytes and emits HDR/LEN/payload/XOR frames; registered tx outputs, len+3 cycles per frame.
// Holds tx_data/tx_valid while tx_ready is low; bytes arriving into a full, unpopped FIFO are dropped and counted.
module i2c_rd_framer
  import i2c_frame_pkg::*;
#(
  parameter int         DEPTH       = 16,
  parameter int         MAX_PAYLOAD = 8,
  parameter int         TIMEOUT     = 50000,
  parameter logic [7:0] HEADER      = HEADER_DEFAULT
) (
  input  logic                   clk50mhz,
  input  logic                   rst,
  input  logic [7:0]             rcv_data,
  input  logic                   recv_done,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic                   clr_ovf,
  output logic                   overflow,
  output logic [7:0]             drop_cnt,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   busy
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO    = TW'(TIMEOUT);
  localparam logic [CW-1:0] MAXP_C = CW'(MAX_PAYLOAD);

  logic [2:0]    state_q, state_d;
  logic          prev_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    len_q, len_d, rem_q, rem_d, csum_q, csum_d;
  logic [7:0]    tx_data_q, tx_data_d, drop_q, drop_d;
  logic          tx_valid_q, tx_valid_d, ovf_q, ovf_d;

  logic [7:0]    fifo_rdata, fifo_rnext;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic          cap, accept, pop, drop, start;

  assign cap    = recv_done & ~prev_q;
  assign accept = tx_valid_q & tx_ready;
  assign pop    = accept & (state_q == ST_PAYLOAD) & ~fifo_empty;
  assign drop   = cap & fifo_full & ~pop;
  assign start  = (state_q == ST_IDLE) &
                  ((fifo_cnt >= MAXP_C) | ((fifo_cnt != '0) & (timer_q == TMO)));

  rx_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk50mhz),
    .rst_i   (rst),
    .push_i  (cap),
    .wdata_i (rcv_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .rnext_o (fifo_rnext),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rem_d      = rem_q;
    csum_d     = csum_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d    = ST_HDR;
        len_d      = (fifo_cnt >= MAXP_C) ? 8'(MAX_PAYLOAD) : 8'(fifo_cnt);
        tx_valid_d = 1'b1;
        tx_data_d  = HEADER;
      end
      ST_HDR: if (accept) begin
        state_d   = ST_LEN;
        csum_d    = len_q;
        tx_data_d = len_q;
      end
      ST_LEN: if (accept) begin
        state_d   = ST_PAYLOAD;
        rem_d     = len_q;
        tx_data_d = fifo_rdata;
      end
      ST_PAYLOAD: if (accept) begin
        csum_d = csum_upd(csum_q, tx_data_q);
        rem_d  = rem_q - 8'd1;
        if (rem_q == 8'd1) begin
          state_d   = ST_CSUM;
          tx_data_d = csum_d;
        end else begin
          tx_data_d = fifo_rnext;
        end
      end
      ST_CSUM: if (accept) begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
      end
      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
      end
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    if ((state_q != ST_IDLE) || (fifo_cnt == '0) || cap) timer_d = '0;
    else if (timer_q != TMO)                             timer_d = timer_q + TW'(1);
  end

  // A drop in the same cycle as clr_ovf takes precedence and counts as the first drop.
  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (clr_ovf) begin
      ovf_d  = 1'b0;
      drop_d = 8'd0;
    end
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = clr_ovf ? 8'd1 : ((drop_q == 8'hFF) ? drop_q : drop_q + 8'd1);
    end
  end

  always_ff @(posedge clk50mhz) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      prev_q     <= 1'b0;
      timer_q    <= '0;
      len_q      <= 8'd0;
      rem_q      <= 8'd0;
      csum_q     <= 8'd0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      prev_q     <= recv_done;
      timer_q    <= timer_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      csum_q     <= csum_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;
  assign fill     = fifo_cnt;
  assign busy     = (state_q != ST_IDLE);
endmodule

// File: tb/tb_i2c_rd_framer.sv
// Directed bench for i2c_rd_framer: stimulus pushes expected frame bytes, a negedge monitor pops and compares.
module tb_i2c_rd_framer;
  localparam int TMO = 200;

  logic       clk50mhz = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rcv_data = 8'h00;
  logic       recv_done = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic [4:0] fill;
  logic       busy;

  i2c_rd_framer #(.DEPTH(16), .MAX_PAYLOAD(8), .TIMEOUT(TMO), .HEADER(8'hA5)) dut (
    .clk50mhz (clk50mhz),
    .rst      (rst),
    .rcv_data (rcv_data),
    .recv_done(recv_done),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .clr_ovf  (clr_ovf),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .fill     (fill),
    .busy     (busy)
  );

  always #10 clk50mhz = ~clk50mhz;

  logic [7:0] exp_q[$];
  logic [7:0] mon_e;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50mhz);
    #1;
  endtask

  function automatic void push_frame(input logic [7:0] b[$]);
    logic [7:0] cs;
    cs = 8'(b.size());
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(b.size()));
    foreach (b[i]) begin
      exp_q.push_back(b[i]);
      cs = cs ^ b[i];
    end
    exp_q.push_back(cs);
  endfunction

  task automatic pulse(input logic [7:0] b, input int hi, input int lo);
    rcv_data  = b;
    recv_done = 1'b1;
    repeat (hi) tick();
    recv_done = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic wait_valid(input string name, input int max);
    int n = 0;
    while (!tx_valid && n < max) begin
      tick();
      n++;
    end
    if (!tx_valid) chk({name, "_wait_valid_timeout"}, 0, 1);
  endtask

  task automatic drain(input string name, input int max);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < max) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  always @(negedge clk50mhz) begin
    if (!rst && tx_valid && tx_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream: got unexpected byte %02h, expected none", tx_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (tx_data !== mon_e) begin
          errors++;
          $display("FAIL stream: got %02h, expected %02h", tx_data, mon_e);
        end
      end
    end
  end

  initial begin
    #(20 * 100000);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] rnd[100];
    int n;
    bit seen, bad, done5;

    repeat (3) tick();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_fill", fill, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // 1: full frame of 8, ready held high
    tx_ready = 1'b1;
    q = {};
    for (int i = 1; i <= 8; i++) q.push_back(8'(i));
    push_frame(q);
    for (int i = 1; i <= 8; i++) pulse(8'(i), 1, 1);
    wait_valid("t1", 20);
    n = 0;
    while (tx_valid && n < 50) begin
      n++;
      tick();
    end
    chk("t1_back_to_back_cycles", n, 11);
    chk("t1_busy_after", busy, 0);
    chk("t1_fill_after", fill, 0);

    // 2: partial frame flushed by timeout
    push_frame({8'h10, 8'h20, 8'h30});
    pulse(8'h10, 1, 1);
    pulse(8'h20, 1, 1);
    rcv_data  = 8'h30;
    recv_done = 1'b1;
    tick();
    recv_done = 1'b0;
    n = 0;
    while (!tx_valid && n < TMO + 50) begin
      tick();
      n++;
    end
    chk("t2_timeout_latency", n, TMO + 1);
    drain("t2", 100);

    // 3: held-high recv_done captures once
    push_frame({8'h5A});
    rcv_data  = 8'h5A;
    recv_done = 1'b1;
    repeat (20) tick();
    recv_done = 1'b0;
    chk("t3_single_capture", fill, 1);
    drain("t3", TMO + 100);

    // 4: stalled sink, overflow, clear behaviour
    tx_ready = 1'b0;
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(8'(8'h40 + i));
    push_frame(q);
    q = {};
    for (int i = 8; i < 16; i++) q.push_back(8'(8'h40 + i));
    push_frame(q);
    seen = 0;
    bad  = 0;
    for (int i = 0; i < 20; i++) begin
      rcv_data  = 8'(8'h40 + i);
      recv_done = 1'b1;
      tick();
      if (seen && !(tx_valid && tx_data == 8'hA5)) bad = 1;
      if (tx_valid) seen = 1;
      recv_done = 1'b0;
      tick();
      if (seen && !(tx_valid && tx_data == 8'hA5)) bad = 1;
      if (tx_valid) seen = 1;
    end
    chk("t4_valid_seen", seen, 1);
    chk("t4_stall_hold_a5", bad, 0);
    chk("t4_fill_full", fill, 16);
    chk("t4_overflow", overflow, 1);
    chk("t4_drop_cnt", drop_cnt, 4);
    rcv_data  = 8'h77;
    recv_done = 1'b1;
    clr_ovf   = 1'b1;
    tick();
    recv_done = 1'b0;
    clr_ovf   = 1'b0;
    chk("t4_drop_wins_ovf", overflow, 1);
    chk("t4_drop_wins_cnt", drop_cnt, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t4_clr_ovf", overflow, 0);
    chk("t4_clr_cnt", drop_cnt, 0);
    tx_ready = 1'b1;
    drain("t4", 200);

    // 5: 100 bytes under random throttling
    q = {};
    for (int i = 0; i < 100; i++) begin
      rnd[i] = 8'($urandom_range(0, 255));
      q.push_back(rnd[i]);
      if (q.size() == 8) begin
        push_frame(q);
        q = {};
      end
    end
    push_frame(q);
    done5 = 0;
    fork
      begin
        for (int i = 0; i < 100; i++) pulse(rnd[i], 1, 5);
        done5 = 1;
      end
      begin
        int g = 0;
        while (g < 20000 && !(done5 && exp_q.size() == 0 && !busy)) begin
          tx_ready = 1'($urandom_range(0, 1));
          tick();
          g++;
        end
      end
    join
    tx_ready = 1'b1;
    chk("t5_queue_empty", exp_q.size(), 0);
    chk("t5_no_overflow", overflow, 0);
    chk("t5_fill", fill, 0);

    // 6: reset during payload aborts frame
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(8'(8'h81 + i));
    push_frame(q);
    for (int i = 0; i < 8; i++) pulse(8'(8'h81 + i), 1, 1);
    wait_valid("t6", 20);
    repeat (3) tick();
    chk("t6_busy_mid_frame", busy, 1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    chk("t6_rst_tx_valid", tx_valid, 0);
    chk("t6_rst_fill", fill, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_tx_data", tx_data, 0);
    push_frame({8'hC3});
    pulse(8'hC3, 1, 1);
    drain("t6", TMO + 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
